// File: rtl/psk_phase_selector_if.sv
// Symbol-in / phase-out handshake bundle for psk_phase_selector.
interface psk_phase_selector_if #(
  parameter int SEL_W   = 3,
  parameter int PHASE_W = 3
);
  logic               sym_valid;
  logic               sym_ready;
  logic [SEL_W-1:0]   sym_data;
  logic               out_valid;
  logic               out_ready;
  logic [PHASE_W-1:0] out_phase;
  logic [SEL_W-1:0]   out_index;

  modport master (
    output sym_valid, sym_data, out_ready,
    input  sym_ready, out_valid, out_phase, out_index
  );

  modport slave (
    input  sym_valid, sym_data, out_ready,
    output sym_ready, out_valid, out_phase, out_index
  );
endinterface

// File: rtl/psk_phase_selector.sv
// Registered M-PSK phase selector: optional Gray decode and differential
// accumulation, table lookup, and a 2-entry output buffer whose head entry
// drives the outputs directly from flops.
module psk_phase_selector #(
  parameter int SEL_W   = 3,
  parameter int PHASE_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [(2**SEL_W)*PHASE_W-1:0]   phase_table,
  input  logic                            gray_en,
  input  logic                            diff_en,
  output logic [CNT_W-1:0]                sym_count,
  psk_phase_selector_if.slave             bus
);

  logic [SEL_W-1:0]   g;
  logic [SEL_W-1:0]   idx;
  logic [PHASE_W-1:0] new_phase;
  logic               push;
  logic               pop;

  logic [SEL_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sym_ready_q, sym_ready_d;
  // Head slot is what the outputs show; tail slot is the second buffer entry.
  logic               head_v_q, head_v_d;
  logic [PHASE_W-1:0] head_p_q, head_p_d;
  logic [SEL_W-1:0]   head_i_q, head_i_d;
  logic               tail_v_q, tail_v_d;
  logic [PHASE_W-1:0] tail_p_q, tail_p_d;
  logic [SEL_W-1:0]   tail_i_q, tail_i_d;

  // Decode the incoming symbol to a table index and look up its phase.
  always_comb begin
    g = bus.sym_data;
    if (gray_en) begin
      g[SEL_W-1] = bus.sym_data[SEL_W-1];
      for (int i = SEL_W - 2; i >= 0; i--) begin
        g[i] = g[i+1] ^ bus.sym_data[i];
      end
    end
    idx       = diff_en ? (acc_q + g) : g;
    new_phase = phase_table[idx*PHASE_W +: PHASE_W];
  end

  // Buffer, accumulator and counter next state. Pushes are gated by the
  // registered ready, so a pop at full never admits a push in the same cycle.
  always_comb begin
    push     = bus.sym_valid & sym_ready_q;
    pop      = head_v_q & bus.out_ready;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    head_v_d = head_v_q;
    head_p_d = head_p_q;
    head_i_d = head_i_q;
    tail_v_d = tail_v_q;
    tail_p_d = tail_p_q;
    tail_i_d = tail_i_q;

    if (push) begin
      acc_d = idx;
      cnt_d = cnt_q + 1'b1;
    end

    if (pop) begin
      if (tail_v_q) begin
        head_p_d = tail_p_q;
        head_i_d = tail_i_q;
        tail_v_d = push;
        if (push) begin
          tail_p_d = new_phase;
          tail_i_d = idx;
        end
      end else begin
        head_v_d = push;
        if (push) begin
          head_p_d = new_phase;
          head_i_d = idx;
        end
      end
    end else if (push) begin
      if (!head_v_q) begin
        head_v_d = 1'b1;
        head_p_d = new_phase;
        head_i_d = idx;
      end else begin
        tail_v_d = 1'b1;
        tail_p_d = new_phase;
        tail_i_d = idx;
      end
    end

    sym_ready_d = !(head_v_d & tail_v_d);
  end

  // State registers with synchronous reset; reset discards buffered entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sym_ready_q <= 1'b0;
      head_v_q    <= 1'b0;
      head_p_q    <= '0;
      head_i_q    <= '0;
      tail_v_q    <= 1'b0;
      tail_p_q    <= '0;
      tail_i_q    <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sym_ready_q <= sym_ready_d;
      head_v_q    <= head_v_d;
      head_p_q    <= head_p_d;
      head_i_q    <= head_i_d;
      tail_v_q    <= tail_v_d;
      tail_p_q    <= tail_p_d;
      tail_i_q    <= tail_i_d;
    end
  end

  assign bus.sym_ready = sym_ready_q;
  assign bus.out_valid = head_v_q;
  assign bus.out_phase = head_p_q;
  assign bus.out_index = head_i_q;
  assign sym_count     = cnt_q;

endmodule

// File: tb/tb_psk_phase_selector.sv
// Scoreboard bench for psk_phase_selector (SEL_W=PHASE_W=3, CNT_W=4).
module tb_psk_phase_selector;

  logic        clk;
  logic        reset;
  logic [23:0] phase_table;
  logic        gray_en;
  logic        diff_en;
  logic [3:0]  sym_count;

  psk_phase_selector_if #(.SEL_W(3), .PHASE_W(3)) bus ();

  psk_phase_selector #(.SEL_W(3), .PHASE_W(3), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .phase_table (phase_table),
    .gray_en     (gray_en),
    .diff_en     (diff_en),
    .sym_count   (sym_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;
  logic [2:0] m_acc;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: Gray decode, differential accumulate, table lookup.
  task automatic push_exp(input logic [2:0] s);
    logic [2:0] g;
    logic [2:0] ix;
    g = s;
    if (gray_en) begin
      g[2] = s[2];
      g[1] = s[2] ^ s[1];
      g[0] = s[2] ^ s[1] ^ s[0];
    end
    ix = diff_en ? 3'(m_acc + g) : g;
    m_acc = ix;
    m_cnt = m_cnt + 1;
    exp_q.push_back({phase_table[ix*3 +: 3], ix});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one symbol; returns one step after the edge that accepted it.
  task automatic send(input logic [2:0] s);
    int n;
    bus.sym_valid = 1'b1;
    bus.sym_data  = s;
    n = 0;
    while (!bus.sym_ready && n < 200) begin
      tick();
      n++;
    end
    chk("send_timeout", n, n % 200 == 0 && n != 0 ? 0 : n);
    if (bus.sym_ready) begin
      push_exp(s);
      tick();
    end
    bus.sym_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.sym_valid = 1'b0;
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_phase", bus.out_phase, 0);
    chk("rst_out_index", bus.out_index, 0);
    chk("rst_sym_count", sym_count, 0);
    chk("rst_sym_ready", bus.sym_ready, 0);
    reset = 1'b0;
    exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
    tick();
    chk("post_rst_ready", bus.sym_ready, 1);
  endtask

  // Output monitor: compare each handshake against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_phase", bus.out_phase, mon_e[5:3]);
        chk("sb_index", bus.out_index, mon_e[2:0]);
      end
    end
  end

  initial begin
    int n;
    clk           = 1'b0;
    reset         = 1'b1;
    gray_en       = 1'b0;
    diff_en       = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_data  = '0;
    bus.out_ready = 1'b0;
    m_acc         = '0;
    m_cnt         = 0;
    for (int i = 0; i < 8; i++) phase_table[i*3 +: 3] = 3'(7 - i);

    tick();
    do_reset();

    // Direct map, back-to-back, one-cycle latency
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(3'(i));
      chk("lat_valid", bus.out_valid, 1);
      chk("lat_index", bus.out_index, i);
      chk("lat_phase", bus.out_phase, 7 - i);
    end
    chk("direct_count", sym_count, 8);
    tick();
    chk("empty_valid", bus.out_valid, 0);
    chk("empty_hold_idx", bus.out_index, 7);
    chk("empty_hold_ph", bus.out_phase, 0);

    // Gray decode
    gray_en = 1'b1;
    send(3'b010);
    chk("gray_010_idx", bus.out_index, 3);
    chk("gray_010_ph", bus.out_phase, 4);
    send(3'b100);
    chk("gray_100_idx", bus.out_index, 7);
    gray_en = 1'b0;

    // Differential from reset, with wrap
    do_reset();
    diff_en = 1'b1;
    send(3'd1); chk("diff_1", bus.out_index, 1);
    send(3'd2); chk("diff_2", bus.out_index, 3);
    send(3'd7); chk("diff_3", bus.out_index, 2);
    send(3'd0); chk("diff_acc", bus.out_index, 2);
    diff_en = 1'b0;
    tick();
    tick();

    // Backpressure, late table change must not affect buffered entries
    bus.out_ready = 1'b0;
    bus.sym_valid = 1'b1;
    bus.sym_data  = 3'd1;
    chk("bp_ready_a", bus.sym_ready, 1);
    push_exp(3'd1);
    tick();
    bus.sym_data = 3'd2;
    chk("bp_ready_b", bus.sym_ready, 1);
    push_exp(3'd2);
    tick();
    chk("bp_full_ready", bus.sym_ready, 0);
    chk("bp_head_idx", bus.out_index, 1);
    for (int i = 0; i < 8; i++) phase_table[i*3 +: 3] = 3'(i);
    bus.sym_data = 3'd4;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_ready", bus.sym_ready, 0);
      chk("bp_stable_ph", bus.out_phase, 6);
      chk("bp_count", sym_count, 4'(m_cnt));
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_ready_after_pop", bus.sym_ready, 1);
    chk("bp_head2_idx", bus.out_index, 2);
    chk("bp_head2_ph", bus.out_phase, 5);
    send(3'd4);
    chk("bp_third_idx", bus.out_index, 4);
    chk("bp_third_ph", bus.out_phase, 4);
    for (int i = 0; i < 8; i++) phase_table[i*3 +: 3] = 3'(7 - i);
    tick();

    // Reset while holding two entries with acc=5
    bus.out_ready = 1'b0;
    diff_en = 1'b1;
    send(3'd3);
    send(3'd6);
    chk("mid_full", bus.sym_ready, 0);
    chk("mid_head", bus.out_index, 7);
    do_reset();
    bus.out_ready = 1'b1;
    send(3'd2);
    chk("mid_after_idx", bus.out_index, 2);
    diff_en = 1'b0;

    // Counter wrap with randomized symbols and modes
    do_reset();
    for (int k = 0; k < 17; k++) begin
      gray_en = 1'($urandom_range(0, 1));
      diff_en = 1'($urandom_range(0, 1));
      send(3'($urandom_range(0, 7)));
    end
    chk("wrap_count", sym_count, 1);
    gray_en = 1'b0;
    diff_en = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psk_phase_selector.md
Name: psk_phase_selector

Overview:
- Parametrised, registered successor to the combinational 8-PSK phase multiplexer.
- Maps each incoming M-ary symbol to a phase word from a flat, software-loaded phase table.
- Optional Gray-to-binary decoding and differential (DPSK) phase accumulation.
- Sits between the symbol source and the phase-to-I/Q / DDS stage; output is buffered behind a valid/ready handshake.

Parameters:
- SEL_W, 3, symbol width; NPH = 2**SEL_W table entries.
- PHASE_W, 3, width of each phase word.
- CNT_W, 16, width of the accepted-symbol counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- phase_table  in  NPH*PHASE_W  entry i at bits [i*PHASE_W +: PHASE_W].
- gray_en  in  1  1 = sym_data is Gray-coded.
- diff_en  in  1  1 = differential mode.
- sym_valid  in  1  input symbol valid.
- sym_ready  out  1  input ready, registered.
- sym_data  in  SEL_W  input symbol.
- out_valid  out  1  output phase valid.
- out_ready  in  1  downstream ready.
- out_phase  out  PHASE_W  selected phase word.
- out_index  out  SEL_W  table index used.
- sym_count  out  CNT_W  accepted symbols, wraps modulo 2**CNT_W.

Behaviour:
- Acceptance and decoding:
  - Accept when sym_valid && sym_ready.
  - g = gray_en ? gray2bin(sym_data) : sym_data, where b[SEL_W-1] = s[SEL_W-1] and b[i] = b[i+1]^s[i].
  - idx = diff_en ? (acc + g) mod NPH : g.
  - Wrap-around is natural SEL_W-bit overflow.
- Accumulator:
  - acc is SEL_W bits, reset 0.
  - Loaded with idx on every accepted symbol, in both modes, so a switch into diff mode continues from the last emitted index.
  - Unchanged when no symbol is accepted.
- Mode sampling:
  - gray_en, diff_en and phase_table are sampled in the acceptance cycle only.
  - Later changes never alter entries already buffered.
- Output buffer:
  - 2-entry FIFO of {phase_table[idx], idx}.
  - Push on accept; pop when out_valid && out_ready.
  - sym_ready = (fifo_count < 2), registered from the next-state count.
  - Full (count==2): sym_ready=0, no push. An in-cycle pop does not enable a push that same cycle; sym_ready rises the next cycle.
  - Empty: out_valid=0; out_phase and out_index hold their last values.
  - Simultaneous push and pop at count==1: count stays 1, order preserved.
- Latency and throughput:
  - Latency is 1 cycle: a symbol accepted at edge N is presented with out_valid=1 after edge N.
  - Sustained throughput is 1 symbol/cycle while out_ready=1.
- Output contract:
  - out_phase/out_index are the head entry, registered.
  - They are stable while out_valid && !out_ready.
- sym_count increments by 1 per accepted symbol; wraps from 2**CNT_W-1 to 0.
- Reset, including mid-transfer:
  - FIFO is emptied; buffered entries are discarded.
  - out_valid=0, out_phase=0, out_index=0, acc=0, sym_count=0.
  - sym_ready=0 during the reset cycle and 1 from the first cycle after reset deasserts.
- No combinational path from any input to any output.

Test Plan:
- Direct map: table entry i = 7-i (SEL_W=PHASE_W=3), gray_en=0, diff_en=0, out_ready=1, symbols 0..7 back-to-back.
  - Expect out_phase 7,6,...,0 one cycle after each accept, out_index 0..7.
  - Expect sym_count=8.
- Gray decode: gray_en=1, sym_data=3'b010.
  - Expect out_index=3, out_phase=table[3].
  - Expect sym_data=3'b100 → out_index=7.
- Differential: diff_en=1 from reset, symbols 1,2,7.
  - Expect out_index 1,3,2 (wrap 3+7=10 mod 8).
  - Expect acc=2 afterwards.
- Backpressure: out_ready=0, send 3 symbols.
  - Expect first two accepted, sym_ready=0 from the cycle after the second accept, third held.
  - Expect out_phase stable.
  - Raise out_ready: order preserved, third accepted one cycle after the first pop.
- Reset mid-operation: FIFO holding 2 entries, acc=5, assert reset one cycle.
  - Expect out_valid=0, out_phase=0, out_index=0, sym_count=0, sym_ready=0 during reset and 1 after.
  - Next diff symbol 2 → out_index 2.
- Counter wrap: CNT_W=4, 17 accepted symbols → sym_count=1.
